// File: rtl/mont_mult_arbiter.sv
// mont_mult_arbiter
//   Shares one Montgomery multiplier between two requesters. Round-robin
//   grant, one multiplication in flight, operands latched at grant and held
//   on mult_a/b/m until the next grant.
//
// Optional feature: define MMA_TIMEOUT_EN to build a WAIT-state watchdog
//   (TIMEOUT_CYCLES). When undefined, err is tied low and WAIT waits forever.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req0/req1               requests (held with operands until ack)
//   a0,b0,m0 / a1,b1,m1     operands per requester
//   ack0/ack1               one-cycle pulse: operands latched
//   done0/done1             one-cycle pulse: result valid
//   result                  last product (holds until next response)
//   err                     qualifies done: 1 = timeout abort
//   busy                    high in every state except IDLE
//   mult_start              one-cycle start pulse to the multiplier
//   mult_a/mult_b/mult_m    latched operands to the multiplier
//   mult_result, mult_done  multiplier result and level done
//
// state  | meaning
// IDLE   | arbitrate, latch winner operands
// LAUNCH | pulse mult_start and ack[owner]
// GUARD  | ignore stale mult_done from the previous operation
// WAIT   | wait for mult_done (or watchdog)
// RESP   | pulse done[owner]
module mont_mult_arbiter #(
  parameter int WIDTH          = 1024,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] m0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] m1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic [WIDTH-1:0] mult_m,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_done
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             win;

`ifdef MMA_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic          err_q, err_d;
  logic [CW-1:0] tmr_q, tmr_d;
`endif

  // On a tie the requester not served last wins; otherwise the only requester.
  assign win = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    result_d = result_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    start_d  = 1'b0;
`ifdef MMA_TIMEOUT_EN
    err_d    = err_q;
    tmr_d    = tmr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          last_d  = win;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          m_d     = win ? m1 : m0;
          ack0_d  = ~win;
          ack1_d  = win;
          start_d = 1'b1;
          state_d = S_LAUNCH;
`ifdef MMA_TIMEOUT_EN
          tmr_d   = TMR_LOAD;
`endif
        end
      end
      S_LAUNCH: state_d = S_GUARD;
      S_GUARD:  state_d = S_WAIT;
      S_WAIT: begin
        // mult_done wins over an expiring watchdog in the same cycle.
        if (mult_done) begin
          result_d = mult_result;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = S_RESP;
`ifdef MMA_TIMEOUT_EN
          err_d    = 1'b0;
        end else if (tmr_q == '0) begin
          result_d = '0;
          err_d    = 1'b1;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = S_RESP;
        end else begin
          tmr_d    = tmr_q - 1'b1;
`endif
        end
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MMA_TIMEOUT_EN
      err_q    <= 1'b0;
      tmr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      result_q <= result_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
`ifdef MMA_TIMEOUT_EN
      err_q    <= err_d;
      tmr_q    <= tmr_d;
`endif
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign result     = result_q;
  assign busy       = busy_q;
  assign mult_start = start_q;
  assign mult_a     = a_q;
  assign mult_b     = b_q;
  assign mult_m     = m_q;
`ifdef MMA_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: doc/mont_mult_arbiter.md
# mont_mult_arbiter

Two-requester arbiter and sequencer sharing one Montgomery multiplier (`montgomery`, 1024-bit) between two clients, e.g. the square and multiply paths of a dual exponentiation engine, or the two CRT half-exponentiations. It takes requests, latches operands, drives the multiplier's start pulse and operands, waits for its done, and returns the product with a one-cycle done pulse. Round-robin fairness; one multiplication in flight at a time.

## Interface

- `WIDTH`, 1024: operand/result width; must match the multiplier.
- `TIMEOUT_CYCLES`, 1048575: watchdog limit in cycles. Used only with `MMA_TIMEOUT_EN`.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request; the requester holds it and its operands stable until its `ack`.
- `a0`, `b0`, `m0` / `a1`, `b1`, `m1`  in  WIDTH each  operands A, B and modulus M for each requester.
- `ack0`, `ack1`  out  1  one-cycle pulse: request accepted, operands latched; the requester may change its operands and drop `req`.
- `done0`, `done1`  out  1  one-cycle pulse: `result` is valid for this requester.
- `result`  out  WIDTH  last product; holds until the next response.
- `err`  out  1  qualifies `done0`/`done1`: 1 means timeout abort.
- `busy`  out  1  high in every state except IDLE.
- `mult_start`  out  1  start pulse to the multiplier.
- `mult_a`, `mult_b`, `mult_m`  out  WIDTH  multiplier operands, driven from latched registers.
- `mult_result`  in  WIDTH  multiplier result.
- `mult_done`  in  1  multiplier done. This is a level signal: it stays high after completion until the next start.

## Operation

- States: IDLE, LAUNCH, GUARD, WAIT, RESP.
- **IDLE**:
  - If either `req` is sampled high, pick the winner.
  - If only one is high, it wins.
  - If both are high, the requester not served last wins; the `last` register resets to 1, so requester 0 wins the first tie.
  - Latch the winner's a/b/m into the operand registers and its index into `owner`, update `last`, then go to LAUNCH.
- **LAUNCH**, one cycle: `mult_start`=1 and `ack[owner]`=1. Next state GUARD.
- **GUARD**, one cycle: `mult_done` is ignored here, because the stale done from the previous operation may still be high. Next state WAIT.
- **WAIT**: on `mult_done`=1, capture `mult_result` into `result`, set `err`=0 and go to RESP.
- **RESP**, one cycle: `done[owner]`=1. Next state IDLE.
- `mult_a/b/m` hold the latched values from LAUNCH through RESP. They change only on the next IDLE grant.
- A `req` that is high outside IDLE is not lost: it is serviced at the next IDLE evaluation.
- `reqN` must stay low from its `ackN` until its `doneN`. Re-assertion in that window is treated as a new request after RESP.
- No arithmetic is done in the arbiter: `result` is a straight copy of `mult_result` (width WIDTH).

## Timing

- Reset value of every output is 0: `ack*`, `done*`, `err`, `busy`, `mult_start`, `mult_a/b/m`, `result`. Reset also forces state IDLE, `last`=1, `owner`=0.
- Reset mid-operation: return to IDLE immediately; no `done` is issued. The multiplier is not reset and may keep running; the next LAUNCH pulse restarts it.
- Latency, with `req` sampled at edge t:
  - LAUNCH in cycle t+1, GUARD in t+2, WAIT from t+3.
  - If `mult_done` is first high in cycle t+3+L, `done` is asserted in cycle t+4+L. Total latency is L+4 cycles.
- `mult_start` is exactly one cycle wide per operation and is never asserted in two consecutive cycles.
- Back-to-back: RESP → IDLE → LAUNCH, so at least 2 cycles between a `done` and the next `mult_start`.
- `ack` and `done` for the same request never coincide. `ack0`/`ack1` are mutually exclusive, and so are `done0`/`done1`.

## Configuration

- `MMA_TIMEOUT_EN` defined:
  - A counter runs in WAIT and clears on entry to LAUNCH.
  - If it reaches `TIMEOUT_CYCLES` without `mult_done`, go to RESP with `err`=1 and `result` set to 0.
  - `mult_done` arriving in the same cycle as the limit takes priority, giving a normal completion.
- `MMA_TIMEOUT_EN` undefined:
  - No counter is built and `err` is tied to 0.
  - WAIT waits indefinitely.

## Test plan

- Single request: `req0` with a0=3, b0=R² mod m, m0=odd 1024-bit modulus, and a behavioural multiplier model with L=10 → `ack0` one cycle later, one `mult_start` pulse, `done0` at t+14, `result` equal to the model output, `done1` never asserted.
- Simultaneous `req0`/`req1` out of reset → requester 0 is served first and requester 1 next. Repeat the tie → requester 0 again. Alternation is confirmed over 8 ties.
- Stale done: model keeps `mult_done` high from the previous operation until one cycle after `mult_start` → no early completion; `done` arrives only after the new L.
- `reset` asserted in WAIT → all outputs are 0 next cycle, no `done` is issued, and a new `req1` afterwards completes normally.
- `req1` arrives while requester 0 is in WAIT → it is granted on the IDLE cycle after `done0`; `mult_start` comes 2 cycles after `done0`.
- With `MMA_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, model never asserts done → `done0` with `err`=1 and `result`=0. With done arriving exactly at cycle 50 → `err`=0.
